// File: rtl/regfile_scb_pkg.sv
// Shared widths, bus types and enable constants for the scoreboarded register file.
package regfile_scb_pkg;

    localparam int RegW     = 32;
    localparam int RegNum   = 32;
    localparam int RegAddrW = 5;
    localparam int TagW     = 4;
    localparam int NumRd    = 2;
    localparam int NumWb    = 2;

    typedef logic [RegW-1:0]     RegBus;
    typedef logic [RegAddrW-1:0] RegAddrBus;
    typedef logic [TagW-1:0]     TagBus;

    localparam RegBus ZeroWord    = '0;
    localparam logic  WriteEnable = 1'b1;
    localparam logic  ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_scb_if.sv
// Issue, writeback and read-port bundle between the core and the register file.
interface regfile_scb_if
    import regfile_scb_pkg::*;
#(
    parameter int XLEN   = RegW,
    parameter int REG_AW = RegAddrW,
    parameter int TAG_W  = TagW,
    parameter int NUM_RD = NumRd,
    parameter int NUM_WB = NumWb
) ();

    logic                       rdy;
    logic                       flush;
    logic                       iss_en;
    logic [REG_AW-1:0]          iss_rd;
    logic [TAG_W-1:0]           iss_tag;
    logic [NUM_WB-1:0]          wb_en;
    logic [NUM_WB*REG_AW-1:0]   wb_rd;
    logic [NUM_WB*TAG_W-1:0]    wb_tag;
    logic [NUM_WB*XLEN-1:0]     wb_data;
    logic [NUM_RD-1:0]          re;
    logic [NUM_RD*REG_AW-1:0]   raddr;
    logic [NUM_RD*XLEN-1:0]     rdata;
    logic [NUM_RD-1:0]          rbusy;
    logic [NUM_RD*TAG_W-1:0]    rtag;

    modport master (
        output rdy, flush, iss_en, iss_rd, iss_tag,
        output wb_en, wb_rd, wb_tag, wb_data, re, raddr,
        input  rdata, rbusy, rtag
    );

    modport slave (
        input  rdy, flush, iss_en, iss_rd, iss_tag,
        input  wb_en, wb_rd, wb_tag, wb_data, re, raddr,
        output rdata, rbusy, rtag
    );

endinterface

// File: rtl/regfile_scb_rd_port.sv
// One combinational read port: forwards same-cycle writeback data and busy-clear.
module regfile_scb_rd_port
    import regfile_scb_pkg::*;
#(
    parameter int XLEN   = RegW,
    parameter int REG_AW = RegAddrW,
    parameter int TAG_W  = TagW,
    parameter int NUM_WB = NumWb
) (
    input  logic                     en,
    input  logic [REG_AW-1:0]        raddr,
    input  logic [XLEN-1:0]          reg_val,
    input  logic                     busy_val,
    input  logic [TAG_W-1:0]         tag_val,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]          rdata,
    output logic                     rbusy,
    output logic [TAG_W-1:0]         rtag
);

    logic [XLEN-1:0] fwd_data;
    logic            fwd_clr;

    always_comb begin
        fwd_data = reg_val;
        fwd_clr  = 1'b0;
        rdata    = '0;
        rbusy    = 1'b0;
        rtag     = '0;
        // Ascending scan so the youngest matching commit supplies the data.
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en[i] && wb_rd[i*REG_AW +: REG_AW] == raddr) begin
                fwd_data = wb_data[i*XLEN +: XLEN];
                if (wb_tag[i*TAG_W +: TAG_W] == tag_val) begin
                    fwd_clr = 1'b1;
                end
            end
        end
        if (en == ReadEnable && raddr != '0) begin
            rdata = fwd_data;
            rbusy = busy_val & ~fwd_clr;
            rtag  = tag_val;
        end
    end

endmodule

// File: rtl/regfile_scb.sv
// Multi-port integer register file with busy/tag scoreboard and same-cycle bypass.
module regfile_scb
    import regfile_scb_pkg::*;
#(
    parameter int XLEN    = RegW,
    parameter int REG_NUM = RegNum,
    parameter int REG_AW  = RegAddrW,
    parameter int TAG_W   = TagW,
    parameter int NUM_RD  = NumRd,
    parameter int NUM_WB  = NumWb
) (
    input  logic         clk,
    input  logic         rst,
    regfile_scb_if.slave bus
);

    logic [XLEN-1:0]    regs_reg  [REG_NUM];
    logic [XLEN-1:0]    regs_next [REG_NUM];
    logic [TAG_W-1:0]   tag_reg   [REG_NUM];
    logic [TAG_W-1:0]   tag_next  [REG_NUM];
    logic [REG_NUM-1:0] busy_reg;
    logic [REG_NUM-1:0] busy_next;
    logic               active;

    assign active = ~rst & bus.rdy;

    always_comb begin
        regs_next = regs_reg;
        tag_next  = tag_reg;
        busy_next = busy_reg;
        for (int r = 1; r < REG_NUM; r++) begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (bus.wb_en[i] == WriteEnable &&
                    bus.wb_rd[i*REG_AW +: REG_AW] == REG_AW'(r)) begin
                    regs_next[r] = bus.wb_data[i*XLEN +: XLEN];
                    // A commit from an older producer must not release a newer rename.
                    if (bus.wb_tag[i*TAG_W +: TAG_W] == tag_reg[r]) begin
                        busy_next[r] = 1'b0;
                    end
                end
            end
        end
        if (bus.flush) begin
            busy_next = '0;
        end else if (bus.iss_en && bus.iss_rd != '0) begin
            busy_next[bus.iss_rd] = 1'b1;
            tag_next[bus.iss_rd]  = bus.iss_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_reg[r] <= '0;
                tag_reg[r]  <= '0;
            end
            busy_reg <= '0;
        end else if (bus.rdy) begin
            regs_reg <= regs_next;
            tag_reg  <= tag_next;
            busy_reg <= busy_next;
        end
    end

    logic [NUM_RD-1:0][XLEN-1:0]  rdata_w;
    logic [NUM_RD-1:0]            rbusy_w;
    logic [NUM_RD-1:0][TAG_W-1:0] rtag_w;

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [REG_AW-1:0] ra;
            assign ra = bus.raddr[gi*REG_AW +: REG_AW];

            regfile_scb_rd_port #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW),
                .TAG_W  (TAG_W),
                .NUM_WB (NUM_WB)
            ) u_rd_port (
                .en       (bus.re[gi] & active),
                .raddr    (ra),
                .reg_val  (regs_reg[ra]),
                .busy_val (busy_reg[ra]),
                .tag_val  (tag_reg[ra]),
                .wb_en    (bus.wb_en),
                .wb_rd    (bus.wb_rd),
                .wb_tag   (bus.wb_tag),
                .wb_data  (bus.wb_data),
                .rdata    (rdata_w[gi]),
                .rbusy    (rbusy_w[gi]),
                .rtag     (rtag_w[gi])
            );
        end
    endgenerate

    assign bus.rdata = rdata_w;
    assign bus.rbusy = rbusy_w;
    assign bus.rtag  = rtag_w;

endmodule

// File: tb/tb_regfile_scb.sv
// Directed and randomized bench for regfile_scb against an array-based scoreboard model.
module tb_regfile_scb;

    localparam int XL = 32;
    localparam int RN = 32;
    localparam int AW = 5;
    localparam int TW = 4;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scb_if #(.XLEN(XL), .REG_AW(AW), .TAG_W(TW), .NUM_RD(NR), .NUM_WB(NW)) bus ();

    regfile_scb #(
        .XLEN(XL), .REG_NUM(RN), .REG_AW(AW), .TAG_W(TW), .NUM_RD(NR), .NUM_WB(NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [XL-1:0] m_regs [RN];
    logic          m_busy [RN];
    logic [TW-1:0] m_tag  [RN];

    // Reference: commits applied oldest-first, then flush or rename on top.
    always @(posedge clk or posedge rst) begin
        logic [AW-1:0] a;
        if (rst) begin
            for (int r = 0; r < RN; r++) begin
                m_regs[r] <= '0;
                m_busy[r] <= 1'b0;
                m_tag[r]  <= '0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < NW; i++) begin
                a = bus.wb_rd[i*AW +: AW];
                if (bus.wb_en[i] && a != 0) begin
                    m_regs[a] <= bus.wb_data[i*XL +: XL];
                    if (bus.wb_tag[i*TW +: TW] == m_tag[a]) m_busy[a] <= 1'b0;
                end
            end
            if (bus.flush) begin
                for (int r = 0; r < RN; r++) m_busy[r] <= 1'b0;
            end else if (bus.iss_en && bus.iss_rd != 0) begin
                m_busy[bus.iss_rd] <= 1'b1;
                m_tag[bus.iss_rd]  <= bus.iss_tag;
            end
        end
    end

    always @(negedge clk) begin
        logic [AW-1:0] a;
        logic [XL-1:0] ed;
        logic          eb;
        logic [TW-1:0] et;
        logic          hit;
        for (int k = 0; k < NR; k++) begin
            a   = bus.raddr[k*AW +: AW];
            ed  = '0;
            eb  = 1'b0;
            et  = '0;
            hit = 1'b0;
            if (!rst && bus.rdy && bus.re[k] && a != 0) begin
                ed = m_regs[a];
                for (int i = 0; i < NW; i++) begin
                    if (bus.wb_en[i] && bus.wb_rd[i*AW +: AW] == a) begin
                        ed = bus.wb_data[i*XL +: XL];
                        if (bus.wb_tag[i*TW +: TW] == m_tag[a]) hit = 1'b1;
                    end
                end
                eb = m_busy[a] && !hit;
                et = m_tag[a];
            end
            checks++;
            if (bus.rdata[k*XL +: XL] !== ed || bus.rbusy[k] !== eb || bus.rtag[k*TW +: TW] !== et) begin
                errors++;
                $display("FAIL model port%0d addr=%0d: got data=%h busy=%b tag=%h want data=%h busy=%b tag=%h",
                         k, a, bus.rdata[k*XL +: XL], bus.rbusy[k], bus.rtag[k*TW +: TW], ed, eb, et);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.rdy     = 1'b1;
        bus.flush   = 1'b0;
        bus.iss_en  = 1'b0;
        bus.iss_rd  = '0;
        bus.iss_tag = '0;
        bus.wb_en   = '0;
        bus.wb_rd   = '0;
        bus.wb_tag  = '0;
        bus.wb_data = '0;
        bus.re      = '1;
        bus.raddr   = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wb(input int p, input int r, input int t, input logic [XL-1:0] d);
        bus.wb_en[p]             = 1'b1;
        bus.wb_rd[p*AW +: AW]    = AW'(r);
        bus.wb_tag[p*TW +: TW]   = TW'(t);
        bus.wb_data[p*XL +: XL]  = d;
    endtask

    task automatic iss(input int r, input int t);
        bus.iss_en  = 1'b1;
        bus.iss_rd  = AW'(r);
        bus.iss_tag = TW'(t);
    endtask

    task automatic rd(input int k, input int r);
        bus.raddr[k*AW +: AW] = AW'(r);
    endtask

    function automatic logic [31:0] rdat(input int k);
        return bus.rdata[k*XL +: XL];
    endfunction

    function automatic logic [31:0] rbsy(input int k);
        return {31'd0, bus.rbusy[k]};
    endfunction

    function automatic logic [31:0] rtg(input int k);
        return {28'd0, bus.rtag[k*TW +: TW]};
    endfunction

    initial begin
        idle();
        rd(0, 3);
        #2;
        chk("reset_rdata", rdat(0), 32'h0);
        chk("reset_rbusy", rbsy(0), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Issue then commit
        iss(5, 7);
        cyc(); rd(0, 5); #2;
        chk("issue_rbusy", rbsy(0), 32'h1);
        chk("issue_rtag", rtg(0), 32'h7);
        wb(0, 5, 7, 32'hDEADBEEF); #1;
        chk("commit_bypass_data", rdat(0), 32'hDEADBEEF);
        chk("commit_bypass_busy", rbsy(0), 32'h0);
        cyc(); rd(0, 5); #2;
        chk("commit_reg_data", rdat(0), 32'hDEADBEEF);
        chk("commit_reg_busy", rbsy(0), 32'h0);

        // Stale tag
        iss(5, 7);
        cyc(); iss(5, 9);
        cyc(); rd(0, 5); wb(0, 5, 7, 32'h11); #2;
        chk("stale_bypass_data", rdat(0), 32'h11);
        chk("stale_bypass_busy", rbsy(0), 32'h1);
        chk("stale_bypass_tag", rtg(0), 32'h9);
        cyc(); rd(0, 5); #2;
        chk("stale_reg_data", rdat(0), 32'h11);
        chk("stale_reg_busy", rbsy(0), 32'h1);
        chk("stale_reg_tag", rtg(0), 32'h9);
        wb(0, 5, 9, 32'h22); #1;
        chk("fresh_clear_busy", rbsy(0), 32'h0);
        cyc(); rd(0, 5); #2;
        chk("fresh_reg_busy", rbsy(0), 32'h0);

        // Dual writeback to the same register
        wb(0, 8, 0, 32'hA); wb(1, 8, 0, 32'hB); rd(1, 8); #2;
        chk("dual_bypass_data", rdat(1), 32'hB);
        cyc(); rd(1, 8); #2;
        chk("dual_reg_data", rdat(1), 32'hB);
        iss(8, 3);
        cyc(); iss(8, 2); wb(0, 8, 3, 32'hC); rd(1, 8); #2;
        chk("iss_wb_bypass_data", rdat(1), 32'hC);
        chk("iss_wb_bypass_busy", rbsy(1), 32'h0);
        cyc(); rd(1, 8); #2;
        chk("iss_over_clear_busy", rbsy(1), 32'h1);
        chk("iss_over_clear_tag", rtg(1), 32'h2);
        chk("iss_over_clear_data", rdat(1), 32'hC);

        // Flush
        for (int t = 1; t <= 4; t++) begin
            iss(t, t);
            cyc();
        end
        rd(0, 3); #2;
        chk("pre_flush_busy", rbsy(0), 32'h1);
        bus.flush = 1'b1; iss(6, 5); wb(0, 2, 0, 32'h77);
        cyc(); rd(0, 2); rd(1, 6); #2;
        chk("flush_wb_data", rdat(0), 32'h77);
        chk("flush_x2_busy", rbsy(0), 32'h0);
        chk("flush_x6_busy", rbsy(1), 32'h0);
        cyc(); rd(0, 1); rd(1, 4); #2;
        chk("flush_x1_busy", rbsy(0), 32'h0);
        chk("flush_x4_busy", rbsy(1), 32'h0);

        // Asynchronous reset mid-cycle
        wb(0, 3, 0, 32'h55); iss(3, 1);
        cyc(); rd(0, 3); #1;
        chk("pre_rst_data", rdat(0), 32'h55);
        chk("pre_rst_busy", rbsy(0), 32'h1);
        #1; rst = 1'b1; #1;
        chk("async_rst_data", rdat(0), 32'h0);
        chk("async_rst_busy", rbsy(0), 32'h0);
        cyc(); rst = 1'b0; rd(0, 3); #2;
        chk("post_rst_data", rdat(0), 32'h0);
        chk("post_rst_busy", rbsy(0), 32'h0);

        // x0 is immutable
        wb(0, 0, 0, 32'hFF); iss(0, 3);
        cyc(); rd(0, 0); #2;
        chk("x0_data", rdat(0), 32'h0);
        chk("x0_busy", rbsy(0), 32'h0);
        chk("x0_tag", rtg(0), 32'h0);

        // rdy=0 freezes everything
        wb(0, 4, 0, 32'h44);
        cyc(); bus.rdy = 1'b0; iss(4, 6); wb(0, 4, 6, 32'h99); rd(0, 4); #2;
        chk("stall_out_data", rdat(0), 32'h0);
        chk("stall_out_busy", rbsy(0), 32'h0);
        cyc(); rd(0, 4); #2;
        chk("stall_hold_data", rdat(0), 32'h44);
        chk("stall_hold_busy", rbsy(0), 32'h0);

        // Randomized traffic biased towards a few registers for collisions
        repeat (3000) begin
            cyc();
            rst        = ($urandom_range(0, 299) == 0);
            bus.rdy    = ($urandom_range(0, 9) != 0);
            bus.flush  = ($urandom_range(0, 24) == 0);
            bus.iss_en = $urandom_range(0, 1);
            bus.iss_rd = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, RN-1));
            bus.iss_tag = TW'($urandom_range(0, 15));
            for (int i = 0; i < NW; i++) begin
                logic [AW-1:0] wr;
                wr = AW'($urandom_range(0, 7));
                bus.wb_en[i]            = $urandom_range(0, 1);
                bus.wb_rd[i*AW +: AW]   = wr;
                bus.wb_tag[i*TW +: TW]  = $urandom_range(0, 1) ? m_tag[wr] : TW'($urandom_range(0, 15));
                bus.wb_data[i*XL +: XL] = $urandom;
            end
            for (int k = 0; k < NR; k++) begin
                bus.re[k]             = ($urandom_range(0, 7) != 0);
                bus.raddr[k*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, RN-1));
            end
        end
        cyc();
        rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
